// File: rtl/spi_sram_port.sv
// Word-wide off-chip memory port: turns one controller read/write handshake into a
// single 40-bit SPI mode-0 frame to a 23LC512-class serial SRAM in sequential mode.
module spi_sram_port #(
  parameter int CLK_DIV = 2,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              ready,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              spi_csb,
  output logic              spi_sclk,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  localparam int FRAME_W = 8 + ADDR_W + DATA_W;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] GAP_LAST = DIV_W'((CLK_DIV > 1) ? CLK_DIV - 2 : 0);
  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_READ  = 8'h03;

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_HIGH, S_LOW, S_GAP} state_e;

  state_e               state_q;
  logic [DIV_W-1:0]     div_q;
  logic [5:0]           bit_q;
  logic [FRAME_W-1:0]   sh_q;
  logic                 we_q;
  logic                 ready_q;
  logic                 rdv_q;
  logic [DATA_W-1:0]    rdata_q;
  logic                 csb_q;
  logic                 sclk_q;
  logic                 mosi_q;
  logic [FRAME_W-1:0]   frame;
  logic                 frame_done;

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    frame = {CMD_READ, req_addr, {DATA_W{1'b0}}};
    if (req_we) frame = {CMD_WRITE, req_addr, req_wdata};
  end

  // ready is raised one cycle before the gap ends, so a held req_valid is accepted exactly
  // CLK_DIV cycles after CSB rises; at CLK_DIV = 1 the gap collapses into the last low phase.
  assign frame_done = ((state_q == S_LOW) && (div_q == DIV_LAST) && (bit_q == '0) && (CLK_DIV == 1))
                   || ((state_q == S_GAP) && (div_q == GAP_LAST));

  // NOTE: sequential state uses non-blocking assignments only; the later frame_done
  // assignments intentionally override the case arms within the same edge.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      we_q    <= 1'b0;
      ready_q <= 1'b1;
      rdv_q   <= 1'b0;
      rdata_q <= '0;
      csb_q   <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
    end else begin
      rdv_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid && ready_q) begin
            state_q <= S_SETUP;
            div_q   <= '0;
            bit_q   <= 6'(FRAME_W - 1);
            sh_q    <= frame;
            we_q    <= req_we;
            ready_q <= 1'b0;
            csb_q   <= 1'b0;
            mosi_q  <= frame[FRAME_W-1];
          end
        end
        S_SETUP: begin
          if (div_q == DIV_LAST) begin
            state_q <= S_HIGH;
            div_q   <= '0;
            sclk_q  <= 1'b1;
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        S_HIGH: begin
          if (div_q == DIV_LAST) begin
            state_q <= S_LOW;
            div_q   <= '0;
            sclk_q  <= 1'b0;
            sh_q    <= {sh_q[FRAME_W-2:0], spi_miso};
            mosi_q  <= (bit_q != '0) ? sh_q[FRAME_W-2] : 1'b0;
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        S_LOW: begin
          if (div_q == DIV_LAST) begin
            div_q <= '0;
            if (bit_q == '0) begin
              state_q <= S_GAP;
              csb_q   <= 1'b1;
            end else begin
              state_q <= S_HIGH;
              bit_q   <= bit_q - 6'd1;
              sclk_q  <= 1'b1;
            end
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        S_GAP:   div_q <= div_q + 1'b1;
        default: state_q <= S_IDLE;
      endcase

      // The last 16 MISO bits have landed in the low end of the shift register.
      if (frame_done) begin
        state_q <= S_IDLE;
        div_q   <= '0;
        ready_q <= 1'b1;
        if (!we_q) begin
          rdata_q <= sh_q[DATA_W-1:0];
          rdv_q   <= 1'b1;
        end
      end
    end
  end

  assign ready       = ready_q;
  assign rdata       = rdata_q;
  assign rdata_valid = rdv_q;
  assign spi_csb     = csb_q;
  assign spi_sclk    = sclk_q;
  assign spi_mosi    = mosi_q;

endmodule

// File: tb/tb_spi_sram_port.sv
// Self-checking bench for spi_sram_port: two instances (CLK_DIV = 2 and 1), a serial SRAM
// responder per instance, and frame-level expectations computed from the timing rules.
module tb_spi_sram_port;

  logic        clk = 1'b0;
  logic        rstb;
  logic [1:0]  req_valid, ready, rdv, csb, sclk, mosi, miso;
  logic        req_we;
  logic [15:0] req_addr, req_wdata;
  logic [15:0] rdata   [2];
  logic [15:0] ret     [2];
  logic [15:0] last_rd [2];
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  spi_sram_port #(.CLK_DIV(2)) u_div2 (
    .clk(clk), .rstb(rstb), .req_valid(req_valid[0]), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .ready(ready[0]), .rdata(rdata[0]),
    .rdata_valid(rdv[0]), .spi_csb(csb[0]), .spi_sclk(sclk[0]), .spi_mosi(mosi[0]),
    .spi_miso(miso[0])
  );

  spi_sram_port #(.CLK_DIV(1)) u_div1 (
    .clk(clk), .rstb(rstb), .req_valid(req_valid[1]), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .ready(ready[1]), .rdata(rdata[1]),
    .rdata_valid(rdv[1]), .spi_csb(csb[1]), .spi_sclk(sclk[1]), .spi_mosi(mosi[1]),
    .spi_miso(miso[1])
  );

  // SRAM responder: captures MOSI on each SCLK rise; after 24 command/address rises it
  // presents the stored word MSB first, otherwise random junk.
  for (genvar g = 0; g < 2; g++) begin : g_mon
    int          rc;
    logic [39:0] bits;
    logic        so = 1'b0;
    always @(posedge sclk[g] or negedge csb[g]) begin
      if (sclk[g] && !csb[g]) begin
        rc   = rc + 1;
        bits = {bits[38:0], mosi[g]};
        so   = (rc >= 25) ? ret[g][40-rc] : 1'($urandom);
      end else if (!sclk[g]) begin
        rc   = 0;
        bits = '0;
      end
    end
    assign miso[g] = so;
  end

  function automatic int get_rc(input int u);
    return (u == 0) ? g_mon[0].rc : g_mon[1].rc;
  endfunction

  function automatic logic [39:0] get_bits(input int u);
    return (u == 0) ? g_mon[0].bits : g_mon[1].bits;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a request once ready is seen (sampled at negedge), return just after the accept edge.
  task automatic issue(input int u, input bit we, input logic [15:0] a, input logic [15:0] d,
                       input logic [15:0] w, output int waited);
    waited = 0;
    while (ready[u] !== 1'b1 && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 400) check("issue_timeout", 64'(ready[u]), 64'd1);
    req_we = we; req_addr = a; req_wdata = d; ret[u] = w;
    req_valid[u] = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // mode 0: drop req_valid; 1: hold req_valid with scrambled fields; 2: random busy pulses.
  task automatic watch(input int u, input int cd, input bit we, input logic [15:0] a,
                       input logic [15:0] d, input logic [15:0] w, input int mode);
    int csb_bad = 0, sclk_bad = 0, rdy_bad = 0, rdv_bad = 0;
    logic [39:0] exp_frame;
    bit exp_sclk;
    exp_frame = {(we ? 8'h02 : 8'h03), a, (we ? d : 16'h0000)};
    if (mode == 0) req_valid[u] = 1'b0;
    for (int k = 0; k < 82 * cd; k++) begin
      @(negedge clk);
      exp_sclk = (k >= cd) && (k < 81 * cd) && (((k - cd) / cd) % 2 == 0);
      if (csb[u]  !== (k >= 81 * cd))         csb_bad++;
      if (sclk[u] !== exp_sclk)               sclk_bad++;
      if (ready[u] !== (k == 82 * cd - 1))    rdy_bad++;
      if (rdv[u] !== (!we && k == 82 * cd - 1)) rdv_bad++;
      if (k == 0) check($sformatf("u%0d_setup_mosi", u), 64'(mosi[u]), 64'(exp_frame[39]));
      if (mode == 1) begin
        req_we = 1'($urandom); req_addr = 16'($urandom); req_wdata = 16'($urandom);
      end else if (mode == 2) begin
        req_valid[u] = (k < 80 * cd) ? 1'($urandom) : 1'b0;
        req_we = 1'($urandom); req_addr = 16'($urandom); req_wdata = 16'($urandom);
      end
    end
    if (!we) last_rd[u] = w;
    check($sformatf("u%0d_csb_timing", u), 64'(csb_bad), 64'd0);
    check($sformatf("u%0d_sclk_timing", u), 64'(sclk_bad), 64'd0);
    check($sformatf("u%0d_ready_timing", u), 64'(rdy_bad), 64'd0);
    check($sformatf("u%0d_rdv_timing", u), 64'(rdv_bad), 64'd0);
    check($sformatf("u%0d_sclk_rises", u), 64'(get_rc(u)), 64'd40);
    check($sformatf("u%0d_mosi_frame", u), 64'(get_bits(u)), 64'(exp_frame));
    check($sformatf("u%0d_mosi_idle", u), 64'(mosi[u]), 64'd0);
    check($sformatf("u%0d_rdata", u), 64'(rdata[u]), 64'(last_rd[u]));
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited, n, lows, pulses;
    logic [15:0] a, d, w;
    bit we;
    int u;

    // Reset with random inputs
    rstb = 1'b0;
    req_valid = 2'($urandom); req_we = 1'($urandom);
    req_addr = 16'($urandom); req_wdata = 16'($urandom);
    ret[0] = 16'h0; ret[1] = 16'h0; last_rd[0] = 16'h0; last_rd[1] = 16'h0;
    #22;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst_u%0d_csb", i), 64'(csb[i]), 64'd1);
      check($sformatf("rst_u%0d_sclk", i), 64'(sclk[i]), 64'd0);
      check($sformatf("rst_u%0d_mosi", i), 64'(mosi[i]), 64'd0);
      check($sformatf("rst_u%0d_ready", i), 64'(ready[i]), 64'd1);
      check($sformatf("rst_u%0d_rdata", i), 64'(rdata[i]), 64'd0);
      check($sformatf("rst_u%0d_rdv", i), 64'(rdv[i]), 64'd0);
    end
    req_valid = 2'b00;
    @(negedge clk);
    rstb = 1'b1;
    @(negedge clk);

    // Single write, then single read with a long hold check
    issue(0, 1'b1, 16'h1234, 16'hBEEF, 16'h0000, waited);
    watch(0, 2, 1'b1, 16'h1234, 16'hBEEF, 16'h0000, 0);
    issue(0, 1'b0, 16'h00FF, 16'h0000, 16'hA55A, waited);
    watch(0, 2, 1'b0, 16'h00FF, 16'h0000, 16'hA55A, 0);
    pulses = 0;
    repeat (100) begin
      @(negedge clk);
      if (rdv[0] !== 1'b0) pulses++;
    end
    check("read_hold_rdata", 64'(rdata[0]), 64'hA55A);
    check("read_hold_no_pulse", 64'(pulses), 64'd0);

    // Back-to-back with req_valid held, then busy pulses during the second frame
    issue(0, 1'b1, 16'h0000, 16'h0001, 16'h0000, waited);
    watch(0, 2, 1'b1, 16'h0000, 16'h0001, 16'h0000, 1);
    w = 16'($urandom);
    issue(0, 1'b0, 16'hFFFF, 16'h0000, w, waited);
    check("b2b_accept_at_ready", 64'(waited), 64'd0);
    watch(0, 2, 1'b0, 16'hFFFF, 16'h0000, w, 2);
    lows = 0;
    repeat (50) begin
      @(negedge clk);
      if (csb[0] !== 1'b1) lows++;
    end
    check("busy_no_extra_frame", 64'(lows), 64'd0);

    // Reset mid-frame after the 20th SCLK rise
    issue(0, 1'b1, 16'($urandom), 16'($urandom), 16'h0000, waited);
    req_valid[0] = 1'b0;
    n = 0;
    while (get_rc(0) != 20 && n < 4000) begin
      #1;
      n++;
    end
    if (n >= 4000) check("mid_rst_rc20_timeout", 64'(get_rc(0)), 64'd20);
    #2 rstb = 1'b0;
    #1;
    check("mid_rst_csb", 64'(csb[0]), 64'd1);
    check("mid_rst_sclk", 64'(sclk[0]), 64'd0);
    check("mid_rst_ready", 64'(ready[0]), 64'd1);
    check("mid_rst_rdata", 64'(rdata[0]), 64'd0);
    last_rd[0] = 16'h0; last_rd[1] = 16'h0;
    @(negedge clk);
    rstb = 1'b1;
    @(negedge clk);
    a = 16'($urandom); d = 16'($urandom);
    issue(0, 1'b1, a, d, 16'h0000, waited);
    watch(0, 2, 1'b1, a, d, 16'h0000, 0);

    // CLK_DIV = 1 read
    w = 16'($urandom);
    issue(1, 1'b0, 16'h8000, 16'h0000, w, waited);
    watch(1, 1, 1'b0, 16'h8000, 16'h0000, w, 0);

    // Randomized frames on both instances
    for (int i = 0; i < 6; i++) begin
      u  = int'($urandom_range(1, 0));
      we = 1'($urandom);
      a  = 16'($urandom); d = 16'($urandom); w = 16'($urandom);
      issue(u, we, a, d, w, waited);
      watch(u, (u == 0) ? 2 : 1, we, a, d, w, int'($urandom_range(2, 0)) == 2 ? 2 : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_sram_port.md
# spi_sram_port

Off-chip memory port that services the memory controller's requests. It accepts one word read or write per handshake and executes it as an SPI frame to an external 23LC512-class serial SRAM in sequential mode. It drives the controller's `off_chip_mem_ready` (`ready`) and returns read data. It sits between the memory controller and the chip's SPI pads.

## Interface
- `CLK_DIV`, 2: `clk` cycles per SCLK half-period; legal values are ≥1.
- `ADDR_W`, 16: address width; fixed at 16 by the SRAM command format.
- `DATA_W`, 16: word width; one word is two SRAM bytes, MSB byte first.

- `clk`  in  1  system clock; all logic is on the rising edge.
- `rstb`  in  1  reset; asynchronous assert, active-low.
- `req_valid`  in  1  request from the memory controller.
- `req_we`  in  1  1 = write, 0 = read.
- `req_addr`  in  16  SRAM byte address; sent unmodified.
- `req_wdata`  in  16  write data.
- `ready`  out  1  idle, able to accept a request.
- `rdata`  out  16  last read word; holds its value until the next read completes.
- `rdata_valid`  out  1  one-cycle pulse when `rdata` updates.
- `spi_csb`  out  1  SRAM chip select, active-low.
- `spi_sclk`  out  1  SPI clock, mode 0 (idles low).
- `spi_mosi`  out  1  serial data out, MSB first.
- `spi_miso`  in  1  serial data in from the SRAM.

## Operation
- **Accept:** a request is accepted on a rising edge where `req_valid && ready`.
  - On that edge, `req_we`, `req_addr` and `req_wdata` are captured into a 40-bit shift register: {cmd[7:0], addr[15:0], wdata[15:0]}.
  - cmd = 0x02 for a write, 0x03 for a read. For a read, the data field is 0.
  - After acceptance, changes on the request inputs have no effect.
- **Busy requests:** `req_valid` while `ready` = 0 is ignored. The block does not queue; the controller holds `req_valid` until the request is accepted.
- **States:**
  - IDLE → SETUP on accept.
  - SETUP → SHIFT after CLK_DIV cycles.
  - SHIFT → GAP after bit 0's low phase.
  - GAP → IDLE after CLK_DIV cycles.
- **IDLE:** `ready` = 1, `spi_csb` = 1, `spi_sclk` = 0, `spi_mosi` = 0.
- **SETUP:** `spi_csb` = 0, `spi_sclk` = 0, `spi_mosi` = bit 39.
- **SHIFT:** 40 bits. Each bit is a high phase (CLK_DIV cycles) followed by a low phase (CLK_DIV cycles).
  - `spi_miso` is sampled on the edge that ends the high phase, i.e. the edge driving SCLK low.
  - On that same edge, `spi_mosi` advances to the next bit.
  - A 6-bit bit counter runs 39→0.
- **Read data:** for reads, the MISO bits from bit positions 15..0 (the last 16 SCLKs) form `rdata`, MSB first. MISO during cmd/addr bits is discarded.
- **GAP:** `spi_csb` = 1, `spi_sclk` = 0.
  - On GAP exit, `ready` → 1.
  - For a read, `rdata` is loaded and `rdata_valid` pulses high for one cycle on the same edge.
- **Address wrap:** `req_addr` = 0xFFFF is sent as-is. The second byte wrapping to 0x0000 is the SRAM's behaviour; the block does no address arithmetic.
- **Reset:** when `rstb` falls, the block enters IDLE immediately, at any point in a frame.
  - Outputs: `spi_csb` = 1, `spi_sclk` = 0, `spi_mosi` = 0, `ready` = 1, `rdata` = 0, `rdata_valid` = 0.
  - An aborted frame is not retried.

## Timing
- Take the accept edge as A (cycle 0).
  - `spi_csb` falls at A.
  - The first SCLK rise is at A + CLK_DIV.
  - `spi_csb` rises at A + 81·CLK_DIV. CSB low time is 81·CLK_DIV cycles (162 at CLK_DIV = 2).
  - `ready` is 1 from A + 82·CLK_DIV (164 cycles at the default).
- **Back-to-back:** with `req_valid` held high, the next request is accepted on the edge where `ready` returns. Minimum CSB-high time between frames is exactly CLK_DIV cycles.
- **Read result:** `rdata_valid` coincides with the first cycle of `ready` = 1. `rdata` is stable from that cycle onward.
- **SPI mode 0:** `spi_mosi` is stable across every SCLK rising edge (changes only while SCLK is low or on its falling edge). SCLK period is 2·CLK_DIV cycles.
- **Glitch-free outputs:** all outputs are registered.

## Test plan
- **Reset values:** assert `rstb` low with random inputs → `spi_csb` = 1, `spi_sclk` = 0, `spi_mosi` = 0, `ready` = 1, `rdata` = 0x0000, `rdata_valid` = 0.
- **Single write:** write, addr 0x1234, wdata 0xBEEF, CLK_DIV = 2 → MOSI sampled on 40 SCLK rises = 0x02 12 34 BE EF; CSB low 162 cycles; `ready` at A + 164; `rdata_valid` never pulses.
- **Single read:** read, addr 0x00FF, SRAM model returns 0xA55A → MOSI first 24 bits = 0x03 00 FF; `rdata` = 0xA55A with a one-cycle `rdata_valid` pulse at A + 164; `rdata` still 0xA55A 100 cycles later.
- **Back-to-back and busy pulses:** `req_valid` held high for two requests (write 0x0000←0x0001, then read 0xFFFF) → second accepted at A + 164; CSB high exactly 2 cycles between frames. Extra `req_valid` pulses while busy → no extra frames.
- **Reset mid-frame:** `rstb` low after the 20th SCLK rise → `spi_csb` = 1 and `spi_sclk` = 0 immediately (asynchronous), `ready` = 1. After release, the next write produces a complete, correct 40-bit frame.
- **CLK_DIV = 1:** read addr 0x8000 → SCLK period 2 cycles; CSB low 81 cycles; `ready` and `rdata_valid` at A + 82.
